// File: rtl/ps2_key_encoder_if.sv
// rtl/ps2_key_encoder_if.sv - PS/2 pin inputs and key-event outputs of the encoder
interface ps2_key_encoder_if;
  logic        ps2_clk;
  logic        ps2_data;
  logic [10:0] ps2_key;
  logic        frame_err;

  modport master (
    output ps2_clk,
    output ps2_data,
    input  ps2_key,
    input  frame_err
  );

  modport slave (
    input  ps2_clk,
    input  ps2_data,
    output ps2_key,
    output frame_err
  );
endinterface

// File: rtl/ps2_key_encoder.sv
// rtl/ps2_key_encoder.sv - PS/2 keyboard receiver producing {toggle, pressed, ext, code} events
module ps2_key_encoder #(
  parameter int FILTER      = 4,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic              clk_sys,
  input  logic              RESET_N,
  ps2_key_encoder_if.slave  bus
);

  localparam int FW = $clog2(FILTER) + 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [FW-1:0] FCNT_MAX = FW'(FILTER - 1);
  localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t        state_q, state_d;
  logic          clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d;
  logic          dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d;
  logic          clk_filt_q, clk_filt_d, dat_filt_q, dat_filt_d;
  logic [FW-1:0] clk_cnt_q, clk_cnt_d, dat_cnt_q, dat_cnt_d;
  logic          clk_prev_q, clk_prev_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          parity_q, parity_d;
  logic          ext_q, ext_d, rel_q, rel_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [10:0]   key_q, key_d;
  logic          frame_err_q, frame_err_d;
  logic          fall, timeout, frame_valid;

  always_ff @(posedge clk_sys or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= IDLE;
      clk_s1_q    <= 1'b1;
      clk_s2_q    <= 1'b1;
      dat_s1_q    <= 1'b1;
      dat_s2_q    <= 1'b1;
      clk_filt_q  <= 1'b1;
      dat_filt_q  <= 1'b1;
      clk_cnt_q   <= '0;
      dat_cnt_q   <= '0;
      clk_prev_q  <= 1'b1;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      parity_q    <= 1'b0;
      ext_q       <= 1'b0;
      rel_q       <= 1'b0;
      tmo_q       <= '0;
      key_q       <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      clk_s1_q    <= clk_s1_d;
      clk_s2_q    <= clk_s2_d;
      dat_s1_q    <= dat_s1_d;
      dat_s2_q    <= dat_s2_d;
      clk_filt_q  <= clk_filt_d;
      dat_filt_q  <= dat_filt_d;
      clk_cnt_q   <= clk_cnt_d;
      dat_cnt_q   <= dat_cnt_d;
      clk_prev_q  <= clk_prev_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      parity_q    <= parity_d;
      ext_q       <= ext_d;
      rel_q       <= rel_d;
      tmo_q       <= tmo_d;
      key_q       <= key_d;
      frame_err_q <= frame_err_d;
    end
  end

  // A filtered line only flips after FILTER straight samples disagreeing with it.
  always_comb begin
    clk_s1_d   = bus.ps2_clk;
    clk_s2_d   = clk_s1_q;
    dat_s1_d   = bus.ps2_data;
    dat_s2_d   = dat_s1_q;
    clk_filt_d = clk_filt_q;
    dat_filt_d = dat_filt_q;
    clk_cnt_d  = '0;
    dat_cnt_d  = '0;
    if (clk_s2_q != clk_filt_q) begin
      if (clk_cnt_q == FCNT_MAX) clk_filt_d = clk_s2_q;
      else                       clk_cnt_d  = clk_cnt_q + 1'b1;
    end
    if (dat_s2_q != dat_filt_q) begin
      if (dat_cnt_q == FCNT_MAX) dat_filt_d = dat_s2_q;
      else                       dat_cnt_d  = dat_cnt_q + 1'b1;
    end
    clk_prev_d = clk_filt_q;
  end

  assign fall        = clk_prev_q & ~clk_filt_q;
  assign timeout     = (state_q != IDLE) && (tmo_q == TMO_MAX) && !fall;
  assign frame_valid = dat_filt_q & (^{shreg_q, parity_q});

  always_comb begin
    state_d = state_q;
    if (fall) begin
      case (state_q)
        IDLE:    if (!dat_filt_q) state_d = DATA;
        DATA:    if (bit_cnt_q == 3'd7) state_d = PARITY;
        PARITY:  state_d = STOP;
        default: state_d = IDLE;
      endcase
    end else if (timeout) begin
      state_d = IDLE;
    end
  end

  always_comb begin
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    parity_d    = parity_q;
    ext_d       = ext_q;
    rel_d       = rel_q;
    key_d       = key_q;
    frame_err_d = 1'b0;
    tmo_d       = (state_q == IDLE || fall || timeout) ? '0 : tmo_q + 1'b1;
    if (fall) begin
      case (state_q)
        IDLE:   bit_cnt_d = '0;
        DATA: begin
          shreg_d   = {dat_filt_q, shreg_q[7:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
        PARITY: parity_d = dat_filt_q;
        default: begin
          if (!frame_valid) begin
            frame_err_d = 1'b1;
            ext_d       = 1'b0;
            rel_d       = 1'b0;
          end else begin
            case (shreg_q)
              8'hE0: ext_d = 1'b1;
              8'hF0: rel_d = 1'b1;
              // Controller responses carry no key information and reset any prefix.
              8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF: begin
                ext_d = 1'b0;
                rel_d = 1'b0;
              end
              default: begin
                key_d = {~key_q[10], ~rel_q, ext_q, shreg_q};
                ext_d = 1'b0;
                rel_d = 1'b0;
              end
            endcase
          end
        end
      endcase
    end else if (timeout) begin
      frame_err_d = 1'b1;
      ext_d       = 1'b0;
      rel_d       = 1'b0;
    end
  end

  assign bus.ps2_key   = key_q;
  assign bus.frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_key_encoder.sv
// tb/tb_ps2_key_encoder.sv - directed self-checking bench for ps2_key_encoder
module tb_ps2_key_encoder;
  localparam int HALF        = 16;
  localparam int TIMEOUT_CYC = 4096;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   errors     = 0;
  int   checks     = 0;
  int   err_cycles = 0;
  int   err_snap;

  ps2_key_encoder_if bus();

  ps2_key_encoder #(.FILTER(4), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk_sys (clk),
    .RESET_N (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (bus.frame_err === 1'b1) err_cycles++;

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    bus.ps2_data = b;
    idle(HALF);
    bus.ps2_clk = 1'b0;
    idle(HALF);
    bus.ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(~(^b) ^ bad_par);
    send_bit(1'b1);
    idle(8);
  endtask

  task automatic test_reset;
    checks++;
    if (bus.ps2_key !== 11'h000) begin
      errors++; $display("FAIL reset_key: got %h want 000", bus.ps2_key);
    end
    checks++;
    if (bus.frame_err !== 1'b0) begin
      errors++; $display("FAIL reset_err: got %b want 0", bus.frame_err);
    end
  endtask

  task automatic test_make_latency;
    logic [7:0] b;
    b = 8'h1C;
    err_snap = err_cycles;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(1'b0);
    bus.ps2_data = 1'b1;
    idle(HALF);
    bus.ps2_clk = 1'b0;
    idle(6);
    checks++;
    if (bus.ps2_key !== 11'h000) begin
      errors++; $display("FAIL make_early: got %h want 000", bus.ps2_key);
    end
    idle(1);
    checks++;
    if (bus.ps2_key !== 11'h61C) begin
      errors++; $display("FAIL make_1c: got %h want 61c", bus.ps2_key);
    end
    idle(HALF - 7);
    bus.ps2_clk = 1'b1;
    idle(8);
    checks++;
    if (err_cycles != err_snap) begin
      errors++; $display("FAIL make_err: got %0d want 0", err_cycles - err_snap);
    end
  endtask

  task automatic test_break;
    send_frame(8'hF0, 1'b0);
    checks++;
    if (bus.ps2_key !== 11'h61C) begin
      errors++; $display("FAIL break_f0_hold: got %h want 61c", bus.ps2_key);
    end
    send_frame(8'h1C, 1'b0);
    checks++;
    if (bus.ps2_key !== 11'h01C) begin
      errors++; $display("FAIL break_1c: got %h want 01c", bus.ps2_key);
    end
  endtask

  task automatic test_ext_break;
    send_frame(8'hE0, 1'b0);
    send_frame(8'hF0, 1'b0);
    checks++;
    if (bus.ps2_key !== 11'h01C) begin
      errors++; $display("FAIL ext_prefix_hold: got %h want 01c", bus.ps2_key);
    end
    send_frame(8'h75, 1'b0);
    checks++;
    if (bus.ps2_key !== 11'h575) begin
      errors++; $display("FAIL ext_break_75: got %h want 575", bus.ps2_key);
    end
  endtask

  task automatic test_parity_err;
    send_frame(8'hE0, 1'b0);
    err_snap = err_cycles;
    send_frame(8'h1C, 1'b1);
    checks++;
    if (err_cycles - err_snap != 1) begin
      errors++; $display("FAIL parity_err_width: got %0d want 1", err_cycles - err_snap);
    end
    checks++;
    if (bus.ps2_key !== 11'h575) begin
      errors++; $display("FAIL parity_key_hold: got %h want 575", bus.ps2_key);
    end
    send_frame(8'h75, 1'b0);
    checks++;
    if (bus.ps2_key !== 11'h275) begin
      errors++; $display("FAIL parity_ext_cleared: got %h want 275", bus.ps2_key);
    end
  endtask

  task automatic test_timeout;
    err_snap = err_cycles;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    idle(1000);
    checks++;
    if (err_cycles != err_snap) begin
      errors++; $display("FAIL timeout_early: got %0d want 0", err_cycles - err_snap);
    end
    idle(TIMEOUT_CYC);
    checks++;
    if (err_cycles - err_snap != 1) begin
      errors++; $display("FAIL timeout_err: got %0d want 1", err_cycles - err_snap);
    end
    checks++;
    if (bus.ps2_key !== 11'h275) begin
      errors++; $display("FAIL timeout_key_hold: got %h want 275", bus.ps2_key);
    end
    send_frame(8'h29, 1'b0);
    checks++;
    if (bus.ps2_key !== 11'h629) begin
      errors++; $display("FAIL timeout_next_29: got %h want 629", bus.ps2_key);
    end
  endtask

  task automatic test_controller_bytes;
    send_frame(8'hFA, 1'b0);
    checks++;
    if (bus.ps2_key !== 11'h629) begin
      errors++; $display("FAIL ctrl_fa_drop: got %h want 629", bus.ps2_key);
    end
    send_frame(8'hE0, 1'b0);
    send_frame(8'hFA, 1'b0);
    send_frame(8'h1C, 1'b0);
    checks++;
    if (bus.ps2_key !== 11'h21C) begin
      errors++; $display("FAIL ctrl_clears_ext: got %h want 21c", bus.ps2_key);
    end
  endtask

  task automatic test_glitch;
    err_snap = err_cycles;
    bus.ps2_data = 1'b0;
    idle(4);
    for (int i = 0; i < 3; i++) begin
      bus.ps2_clk = 1'b0;
      idle(2);
      bus.ps2_clk = 1'b1;
      idle(10);
    end
    bus.ps2_data = 1'b1;
    idle(10);
    send_frame(8'h34, 1'b0);
    checks++;
    if (bus.ps2_key !== 11'h634) begin
      errors++; $display("FAIL glitch_frame_34: got %h want 634", bus.ps2_key);
    end
    checks++;
    if (err_cycles != err_snap) begin
      errors++; $display("FAIL glitch_err: got %0d want 0", err_cycles - err_snap);
    end
  endtask

  task automatic test_reset_midframe;
    send_bit(1'b0);
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    rst_n = 1'b0;
    idle(1);
    checks++;
    if (bus.ps2_key !== 11'h000) begin
      errors++; $display("FAIL midreset_key: got %h want 000", bus.ps2_key);
    end
    checks++;
    if (bus.frame_err !== 1'b0) begin
      errors++; $display("FAIL midreset_err: got %b want 0", bus.frame_err);
    end
    idle(3);
    rst_n = 1'b1;
    idle(8);
    send_frame(8'h16, 1'b0);
    checks++;
    if (bus.ps2_key !== 11'h616) begin
      errors++; $display("FAIL midreset_next_16: got %h want 616", bus.ps2_key);
    end
  endtask

  initial begin
    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    rst_n        = 1'b0;
    idle(4);
    test_reset;
    rst_n = 1'b1;
    idle(8);
    test_make_latency;
    test_break;
    test_ext_break;
    test_parity_err;
    test_timeout;
    test_controller_bytes;
    test_glitch;
    test_reset_midframe;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
